// File: rtl/gpio_pkg.sv
// ---------------------------------------------------------------------------
// gpio_pkg
// Shared definitions for the APB GPIO bank: register address map, the
// default ID register value and the APB slave FSM state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package gpio_pkg;

    // Register address map (word index on paddr)
    localparam int unsigned ADDR_OUT    = 0;
    localparam int unsigned ADDR_DIR    = 1;
    localparam int unsigned ADDR_IN     = 2;
    localparam int unsigned ADDR_IE     = 3;
    localparam int unsigned ADDR_POL    = 4;
    localparam int unsigned ADDR_ISTAT  = 5;
    localparam int unsigned ADDR_TOGGLE = 6;
    localparam int unsigned ADDR_ID     = 7;

    // Value returned by the read-only ID register unless overridden
    localparam logic [7:0] ID_VALUE_DEFAULT = 8'hA5;

    // APB slave phases
    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/gpio_apb_bank_if.sv
// ---------------------------------------------------------------------------
// gpio_apb_bank_if
// APB bus bundle between an upstream bridge (master) and one GPIO bank
// (slave). No error response is carried.
//   psel     bank select
//   penable  access phase
//   pwrite   1=write, 0=read
//   paddr    register address   [ADDR_WIDTH]
//   pwdata   write data         [DATA_WIDTH]
//   prdata   read data          [DATA_WIDTH]
//   pready   transfer complete
// ---------------------------------------------------------------------------
interface gpio_apb_bank_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready
    );
endinterface

// File: rtl/gpio_in_sync.sv
// ---------------------------------------------------------------------------
// gpio_in_sync
// Per-bit two-flop synchronizer for asynchronous GPIO pins, followed by a
// third delay flop used for edge detection.
//   sclk    clock
//   resetn  asynchronous active-low reset (clears all stages)
//   pins    raw asynchronous pin inputs
//   sync    synchronized pin values (second stage)
//   rise    one-cycle pulse per bit on a 0->1 transition of sync
//   fall    one-cycle pulse per bit on a 1->0 transition of sync
// ---------------------------------------------------------------------------
module gpio_in_sync #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  sclk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] pins,
    output logic [DATA_WIDTH-1:0] sync,
    output logic [DATA_WIDTH-1:0] rise,
    output logic [DATA_WIDTH-1:0] fall
);

    logic [DATA_WIDTH-1:0] stage1;
    logic [DATA_WIDTH-1:0] stage2;
    logic [DATA_WIDTH-1:0] stage3;

    always_ff @(posedge sclk or negedge resetn) begin
        if (!resetn) begin
            stage1 <= '0;
            stage2 <= '0;
            stage3 <= '0;
        end else begin
            stage1 <= pins;
            stage2 <= stage1;
            stage3 <= stage2;
        end
    end

    assign sync = stage2;
    assign rise = stage2 & ~stage3;
    assign fall = ~stage2 & stage3;

endmodule

// File: rtl/gpio_apb_bank.sv
// ---------------------------------------------------------------------------
// gpio_apb_bank
// One APB-attached GPIO bank: output/direction registers, synchronized pin
// inputs, per-pin edge interrupt status with polarity select, interrupt
// enable and a registered level interrupt.
//   sclk      clock (also APB pclk); may stop between bus activity
//   resetn    asynchronous active-low reset
//   bus       APB slave port (psel/penable/pwrite/paddr/pwdata/prdata/pready)
//   gpio_in   asynchronous pin inputs
//   gpio_out  pin output values (OUT register)
//   gpio_oe   pin output enables, 1=drive (DIR register)
//   irq       level interrupt, |(ISTAT & IE) registered
// ---------------------------------------------------------------------------
module gpio_apb_bank
    import gpio_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 3,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = DATA_WIDTH'(ID_VALUE_DEFAULT)
) (
    input  logic                  sclk,
    input  logic                  resetn,
    gpio_apb_bank_if.slave        bus,
    input  logic [DATA_WIDTH-1:0] gpio_in,
    output logic [DATA_WIDTH-1:0] gpio_out,
    output logic [DATA_WIDTH-1:0] gpio_oe,
    output logic                  irq
);

    localparam logic [ADDR_WIDTH-1:0] A_OUT    = ADDR_WIDTH'(ADDR_OUT);
    localparam logic [ADDR_WIDTH-1:0] A_DIR    = ADDR_WIDTH'(ADDR_DIR);
    localparam logic [ADDR_WIDTH-1:0] A_IN     = ADDR_WIDTH'(ADDR_IN);
    localparam logic [ADDR_WIDTH-1:0] A_IE     = ADDR_WIDTH'(ADDR_IE);
    localparam logic [ADDR_WIDTH-1:0] A_POL    = ADDR_WIDTH'(ADDR_POL);
    localparam logic [ADDR_WIDTH-1:0] A_ISTAT  = ADDR_WIDTH'(ADDR_ISTAT);
    localparam logic [ADDR_WIDTH-1:0] A_TOGGLE = ADDR_WIDTH'(ADDR_TOGGLE);
    localparam logic [ADDR_WIDTH-1:0] A_ID     = ADDR_WIDTH'(ADDR_ID);

    apb_state_t            state;
    apb_state_t            state_next;
    logic                  enter_access;

    logic                  lat_write;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  commit;

    logic [DATA_WIDTH-1:0] out_q;
    logic [DATA_WIDTH-1:0] dir_q;
    logic [DATA_WIDTH-1:0] ie_q;
    logic [DATA_WIDTH-1:0] pol_q;
    logic [DATA_WIDTH-1:0] istat_q;
    logic [DATA_WIDTH-1:0] istat_next;
    logic [DATA_WIDTH-1:0] istat_clr;
    logic [DATA_WIDTH-1:0] edge_set;

    logic [DATA_WIDTH-1:0] in_sync;
    logic [DATA_WIDTH-1:0] in_rise;
    logic [DATA_WIDTH-1:0] in_fall;
    logic [DATA_WIDTH-1:0] rd_data;

    gpio_in_sync #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_in_sync (
        .sclk   (sclk),
        .resetn (resetn),
        .pins   (gpio_in),
        .sync   (in_sync),
        .rise   (in_rise),
        .fall   (in_fall)
    );

    // APB FSM: state register
    always_ff @(posedge sclk or negedge resetn) begin
        if (!resetn) begin
            state <= APB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // APB FSM: next state. penable seen in IDLE is not a valid setup and is
    // ignored; staying in SETUP while psel=1/penable=0 treats it as a
    // continued setup phase.
    always_comb begin
        state_next = state;
        case (state)
            APB_IDLE: begin
                if (bus.psel && !bus.penable) begin
                    state_next = APB_SETUP;
                end
            end
            APB_SETUP: begin
                if (!bus.psel) begin
                    state_next = APB_IDLE;
                end else if (bus.penable) begin
                    state_next = APB_ACCESS;
                end
            end
            APB_ACCESS: begin
                state_next = APB_IDLE;
            end
            default: begin
                state_next = APB_IDLE;
            end
        endcase
    end

    assign enter_access = (state_next == APB_ACCESS);

    // The write is committed at the end of the ACCESS cycle from values
    // captured on SETUP->ACCESS, so a reset during ACCESS discards it.
    assign commit = (state == APB_ACCESS) && lat_write;

    // Read mux over the register file (registered into prdata below)
    always_comb begin
        rd_data = '0;
        case (bus.paddr)
            A_OUT:    rd_data = out_q;
            A_DIR:    rd_data = dir_q;
            A_IN:     rd_data = in_sync;
            A_IE:     rd_data = ie_q;
            A_POL:    rd_data = pol_q;
            A_ISTAT:  rd_data = istat_q;
            A_TOGGLE: rd_data = '0;
            A_ID:     rd_data = ID_VALUE;
            default:  rd_data = '0;
        endcase
    end

    // Bus response and transfer capture
    always_ff @(posedge sclk or negedge resetn) begin
        if (!resetn) begin
            bus.pready <= 1'b0;
            bus.prdata <= '0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            bus.pready <= enter_access;
            bus.prdata <= (enter_access && !bus.pwrite) ? rd_data : '0;
            if (enter_access) begin
                lat_write <= bus.pwrite;
                lat_addr  <= bus.paddr;
                lat_wdata <= bus.pwdata;
            end else begin
                lat_write <= 1'b0;
            end
        end
    end

    // Interrupt status: edges matching POL set bits independent of IE; a
    // same-cycle W1C loses to a set.
    assign edge_set   = (in_rise & pol_q) | (in_fall & ~pol_q);
    assign istat_clr  = (commit && lat_addr == A_ISTAT) ? lat_wdata : '0;
    assign istat_next = (istat_q & ~istat_clr) | edge_set;

    // Register file and interrupt output
    always_ff @(posedge sclk or negedge resetn) begin
        if (!resetn) begin
            out_q   <= '0;
            dir_q   <= '0;
            ie_q    <= '0;
            pol_q   <= '1;
            istat_q <= '0;
            irq     <= 1'b0;
        end else begin
            if (commit && lat_addr == A_OUT) begin
                out_q <= lat_wdata;
            end else if (commit && lat_addr == A_TOGGLE) begin
                out_q <= out_q ^ lat_wdata;
            end
            if (commit && lat_addr == A_DIR) begin
                dir_q <= lat_wdata;
            end
            if (commit && lat_addr == A_IE) begin
                ie_q <= lat_wdata;
            end
            if (commit && lat_addr == A_POL) begin
                pol_q <= lat_wdata;
            end
            istat_q <= istat_next;
            irq     <= |(istat_q & ie_q);
        end
    end

    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;

endmodule
